// File: rtl/score_renderer_pkg.sv
// Shared GPU command type, screen geometry and score-digit layout defaults.
package score_renderer_pkg;

  localparam int unsigned GPU_COORD_W = 10;
  localparam int unsigned GPU_COLOR_W = 8;
  localparam int unsigned GPU_ADDR_W  = 16;
  localparam int unsigned GPU_SCALE_W = 2;

  localparam int unsigned SCREEN_W = 640;
  localparam int unsigned SCREEN_H = 480;

  // Digit geometry shared with the game controller so both agree on layout.
  localparam int unsigned SR_HOR_OFFSET   = 490;
  localparam int unsigned SR_VER_OFFSET   = 10;
  localparam int unsigned SR_DIGIT_WIDTH  = 40;
  localparam int unsigned SR_DIGIT_HEIGHT = 72;
  localparam int unsigned SR_HOR_GAP      = 10;

  typedef struct packed {
    logic [GPU_COORD_W-1:0] x;
    logic [GPU_COORD_W-1:0] y;
    logic [GPU_COORD_W-1:0] width;
    logic [GPU_COORD_W-1:0] height;
    logic [GPU_COLOR_W-1:0] color;
    logic [GPU_ADDR_W-1:0]  mem_addr;
    logic                   mem_en;
    logic [GPU_SCALE_W-1:0] scale;
  } gpu_op_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CONVERT,
    ST_LOAD,
    ST_ISSUE,
    ST_NEXT
  } sr_state_e;

  // Double-dabble nibble correction applied before each shift.
  function automatic logic [3:0] dd_adjust(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

endpackage

// File: rtl/score_renderer_if.sv
// GPU command FIFO write port: op word, write strobe and full back-pressure.
interface score_renderer_if;
  import score_renderer_pkg::*;

  gpu_op_t op;
  logic    op_wr_en;
  logic    op_full;

  modport master (output op, output op_wr_en, input op_full);
  modport slave  (input op, input op_wr_en, output op_full);
endinterface

// File: rtl/score_renderer_bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one input bit per cycle.
module bin2bcd_seq
  import score_renderer_pkg::*;
#(
  parameter int unsigned BIN_W  = 10,
  parameter int unsigned DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ce,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  valid
);

  localparam int unsigned CNT_W = $clog2(BIN_W + 1);

  logic [BIN_W-1:0]    shift_q, shift_d;
  logic [4*DIGITS-1:0] bcd_q, bcd_d, adj;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  // Per-nibble add-3 correction of the current BCD accumulator.
  always_comb begin
    adj = '0;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      adj[4*k +: 4] = dd_adjust(bcd_q[4*k +: 4]);
    end
  end

  // Load on start, otherwise shift one bit into the BCD accumulator per cycle.
  always_comb begin
    shift_d = shift_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    if (start) begin
      shift_d = bin;
      bcd_d   = '0;
      cnt_d   = CNT_W'(BIN_W);
    end else if (cnt_q != '0) begin
      bcd_d   = (adj << 1) | (4*DIGITS)'(shift_q[BIN_W-1]);
      shift_d = shift_q << 1;
      cnt_d   = cnt_q - 1'b1;
    end
  end

  // Converter state registers, frozen when ce is low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_q <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
    end else if (ce) begin
      shift_q <= shift_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bcd = bcd_q;
  // Raised during the final shift so a consumer advancing on the same enabled
  // edge reads a finished result on the following cycle.
  assign valid = (cnt_q <= CNT_W'(1));

endmodule

// File: rtl/score_renderer.sv
// Saturating decimal score with a render pass that blits one sprite per digit.
module score_renderer
  import score_renderer_pkg::*;
#(
  parameter int unsigned DIGITS        = 3,
  parameter int unsigned HOR_OFFSET    = SR_HOR_OFFSET,
  parameter int unsigned VER_OFFSET    = SR_VER_OFFSET,
  parameter int unsigned DIGIT_WIDTH   = SR_DIGIT_WIDTH,
  parameter int unsigned DIGIT_HEIGHT  = SR_DIGIT_HEIGHT,
  parameter int unsigned HOR_GAP       = SR_HOR_GAP,
  parameter int unsigned MEM_BASE      = 0,
  parameter int unsigned MEM_STRIDE    = 45,
  parameter int unsigned SCALE         = 1,
  parameter int unsigned BLANK_LEADING = 1,
  localparam int unsigned SCORE_WIDTH  = $clog2(10**DIGITS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ce,
  input  logic                   inc,
  input  logic                   clear,
  input  logic                   start,
  output logic [SCORE_WIDTH-1:0] score,
  output logic                   busy,
  output logic                   done,
  score_renderer_if.master       gpu
);

  localparam int unsigned IDX_W = 3;
  localparam int unsigned PITCH = DIGIT_WIDTH + HOR_GAP;
  localparam logic [IDX_W-1:0]       LAST_IDX  = IDX_W'(DIGITS - 1);
  localparam logic [SCORE_WIDTH-1:0] SCORE_MAX = SCORE_WIDTH'(10**DIGITS - 1);

  if (DIGITS < 1 || DIGITS > 6) begin : g_bad_digits
    $error("score_renderer: DIGITS must be in 1..6");
  end
  if (HOR_OFFSET + (DIGITS - 1) * PITCH + DIGIT_WIDTH > SCREEN_W) begin : g_bad_x
    $error("score_renderer: rightmost digit extends past the screen edge");
  end
  if (VER_OFFSET + DIGIT_HEIGHT > SCREEN_H) begin : g_bad_y
    $error("score_renderer: digits extend past the screen bottom");
  end

  sr_state_e              state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic                   seen_q, seen_d;
  gpu_op_t                op_q, op_d;
  logic [SCORE_WIDTH-1:0] score_q, score_d;
  logic [4*DIGITS-1:0]    bcd;
  logic                   conv_valid;
  logic                   conv_start;
  logic [3:0]             digit;
  logic                   skip;

  assign conv_start = (state_q == ST_IDLE) && start;

  bin2bcd_seq #(
    .BIN_W  (SCORE_WIDTH),
    .DIGITS (DIGITS)
  ) u_bin2bcd (
    .clk   (clk),
    .rst   (rst),
    .ce    (ce),
    .start (conv_start),
    .bin   (score_q),
    .bcd   (bcd),
    .valid (conv_valid)
  );

  // Score update: clear wins over inc, inc saturates at the largest value.
  always_comb begin
    score_d = score_q;
    if (clear) begin
      score_d = '0;
    end else if (inc && (score_q != SCORE_MAX)) begin
      score_d = score_q + 1'b1;
    end
  end

  // Score register, frozen when ce is low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      score_q <= '0;
    end else if (ce) begin
      score_q <= score_d;
    end
  end

  // Select the BCD digit at the current index; index 0 is most significant.
  always_comb begin
    digit = '0;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      if (idx_q == IDX_W'(k)) begin
        digit = bcd[4*(DIGITS-1-k) +: 4];
      end
    end
  end

  assign skip = (BLANK_LEADING != 0) && (idx_q != LAST_IDX) &&
                (digit == 4'd0) && !seen_q;

  // FSM state and pass datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      seen_q  <= 1'b0;
      op_q    <= '0;
    end else if (ce) begin
      state_q <= state_d;
      idx_q   <= idx_d;
      seen_q  <= seen_d;
      op_q    <= op_d;
    end
  end

  // Next-state logic and op word construction for the current digit.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    seen_d  = seen_q;
    op_d    = op_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_CONVERT;
      end
      ST_CONVERT: begin
        if (conv_valid) begin
          state_d = ST_LOAD;
          idx_d   = '0;
          seen_d  = 1'b0;
        end
      end
      ST_LOAD: begin
        if (skip) begin
          idx_d = idx_q + 1'b1;
        end else begin
          op_d          = '0;
          op_d.x        = GPU_COORD_W'(HOR_OFFSET) +
                          GPU_COORD_W'(idx_q) * GPU_COORD_W'(PITCH);
          op_d.y        = GPU_COORD_W'(VER_OFFSET);
          op_d.width    = GPU_COORD_W'(DIGIT_WIDTH);
          op_d.height   = GPU_COORD_W'(DIGIT_HEIGHT);
          op_d.mem_addr = GPU_ADDR_W'(MEM_BASE) +
                          GPU_ADDR_W'(digit) * GPU_ADDR_W'(MEM_STRIDE);
          op_d.mem_en   = 1'b1;
          op_d.scale    = GPU_SCALE_W'(SCALE);
          seen_d        = 1'b1;
          state_d       = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (!gpu.op_full) state_d = ST_NEXT;
      end
      ST_NEXT: begin
        if (idx_q == LAST_IDX) begin
          state_d = ST_IDLE;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = ST_LOAD;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs; strobes are qualified by ce so a frozen cycle cannot repeat them.
  always_comb begin
    busy         = (state_q != ST_IDLE);
    gpu.op_wr_en = ce && (state_q == ST_ISSUE) && !gpu.op_full;
    done         = ce && (state_q == ST_NEXT) && (idx_q == LAST_IDX);
  end

  assign gpu.op = op_q;
  assign score  = score_q;

endmodule

// File: tb/tb_score_renderer.sv
// Directed self-checking bench for score_renderer with default parameters.
module tb_score_renderer;
  import score_renderer_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       ce;
  logic       inc;
  logic       clear;
  logic       start;
  logic [9:0] score;
  logic       busy;
  logic       done;

  int checks   = 0;
  int failures = 0;
  gpu_op_t ops[$];

  score_renderer_if gpu_bus ();

  score_renderer dut (
    .clk   (clk),
    .rst   (rst),
    .ce    (ce),
    .inc   (inc),
    .clear (clear),
    .start (start),
    .score (score),
    .busy  (busy),
    .done  (done),
    .gpu   (gpu_bus.master)
  );

  always #5 clk = ~clk;

  // Record every op written to the FIFO, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst === 1'b1 && gpu_bus.op_wr_en === 1'b1) ops.push_back(gpu_bus.op);
  end

  initial begin
    #2ms;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Waits for done with a cycle budget; returns ticks taken.
  task automatic wait_done(output int n);
    n = 0;
    while (done !== 1'b1 && n < 300) begin
      tick(1);
      n++;
    end
  endtask

  // Pulses start and returns the pass length in cycles, start cycle included.
  task automatic run_pass(output int lat);
    int n;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    wait_done(n);
    lat = n + 2;
    tick(1);
  endtask

  task automatic check_op(input string tag, input int k, input int ex, input int ea);
    gpu_op_t o;
    o = '0;
    if (k < ops.size()) o = ops[k];
    check({tag, "_x"},      128'(o.x),        128'(ex));
    check({tag, "_addr"},   128'(o.mem_addr), 128'(ea));
    check({tag, "_y"},      128'(o.y),        128'(10));
    check({tag, "_mem_en"}, 128'(o.mem_en),   128'(1));
  endtask

  initial begin
    int lat;
    int n;
    rst   = 1'b0;
    ce    = 1'b1;
    inc   = 1'b0;
    clear = 1'b0;
    start = 1'b0;
    gpu_bus.op_full = 1'b0;
    tick(3);

    // Reset state
    check("rst_score", 128'(score), 128'(0));
    check("rst_busy",  128'(busy),  128'(0));
    check("rst_done",  128'(done),  128'(0));
    check("rst_wr_en", 128'(gpu_bus.op_wr_en), 128'(0));
    check("rst_op",    128'(gpu_bus.op), 128'(0));
    rst = 1'b1;
    tick(2);

    // Score 0: only the units digit is drawn
    ops.delete();
    run_pass(lat);
    check("zero_latency", 128'(lat), 128'(16));
    check("zero_nops", 128'(ops.size()), 128'(1));
    check_op("zero_op0", 0, 590, 0);
    if (ops.size() > 0) begin
      check("zero_width",  128'(ops[0].width),  128'(40));
      check("zero_height", 128'(ops[0].height), 128'(72));
      check("zero_scale",  128'(ops[0].scale),  128'(1));
      check("zero_color",  128'(ops[0].color),  128'(0));
    end
    check("zero_busy_after", 128'(busy), 128'(0));
    check("zero_done_after", 128'(done), 128'(0));

    // 123 increments
    inc = 1'b1;
    tick(123);
    inc = 1'b0;
    check("score_123", 128'(score), 128'(123));
    ops.delete();
    run_pass(lat);
    check("p123_latency", 128'(lat), 128'(20));
    check("p123_nops", 128'(ops.size()), 128'(3));
    check_op("p123_op0", 0, 490, 45);
    check_op("p123_op1", 1, 540, 90);
    check_op("p123_op2", 2, 590, 135);

    // Clear, then saturate at 999
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    check("clear_score", 128'(score), 128'(0));
    inc = 1'b1;
    tick(1005);
    inc = 1'b0;
    check("sat_score", 128'(score), 128'(999));
    ops.delete();
    run_pass(lat);
    check("sat_nops", 128'(ops.size()), 128'(3));
    check_op("sat_op0", 0, 490, 405);
    check_op("sat_op1", 1, 540, 405);
    check_op("sat_op2", 2, 590, 405);

    // FIFO full stall on a single drawn digit (score 7)
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    inc = 1'b1;
    tick(7);
    inc = 1'b0;
    ops.delete();
    gpu_bus.op_full = 1'b1;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(18);
    check("stall_wr_en_a", 128'(gpu_bus.op_wr_en), 128'(0));
    check("stall_x_a",     128'(gpu_bus.op.x),        128'(590));
    check("stall_addr_a",  128'(gpu_bus.op.mem_addr), 128'(315));
    tick(5);
    check("stall_nops", 128'(ops.size()), 128'(0));
    check("stall_addr_b", 128'(gpu_bus.op.mem_addr), 128'(315));
    check("stall_busy", 128'(busy), 128'(1));
    gpu_bus.op_full = 1'b0;
    wait_done(n);
    check("stall_done_seen", 128'(done), 128'(1));
    tick(3);
    check("stall_nops_after", 128'(ops.size()), 128'(1));
    check_op("stall_op0", 0, 590, 315);

    // inc and clear together, then inc and start during a pass
    inc = 1'b1;
    clear = 1'b1;
    tick(1);
    inc = 1'b0;
    clear = 1'b0;
    check("inc_clear_score", 128'(score), 128'(0));
    inc = 1'b1;
    tick(42);
    inc = 1'b0;
    ops.delete();
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(1);
    inc = 1'b1;
    tick(1);
    inc = 1'b0;
    tick(1);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    wait_done(n);
    check("snap_latency", 128'(n + 6), 128'(18));
    tick(30);
    check("snap_nops", 128'(ops.size()), 128'(2));
    check_op("snap_op0", 0, 540, 180);
    check_op("snap_op1", 1, 590, 90);
    check("snap_score", 128'(score), 128'(43));
    check("snap_busy", 128'(busy), 128'(0));

    // Reset during ISSUE
    ops.delete();
    gpu_bus.op_full = 1'b1;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(16);
    check("mid_busy_before", 128'(busy), 128'(1));
    rst = 1'b0;
    gpu_bus.op_full = 1'b0;
    #1;
    check("mid_wr_en", 128'(gpu_bus.op_wr_en), 128'(0));
    check("mid_busy",  128'(busy),  128'(0));
    check("mid_score", 128'(score), 128'(0));
    check("mid_op",    128'(gpu_bus.op), 128'(0));
    tick(2);
    rst = 1'b1;
    tick(2);
    check("mid_nops", 128'(ops.size()), 128'(0));
    run_pass(lat);
    check("post_latency", 128'(lat), 128'(16));
    check("post_nops", 128'(ops.size()), 128'(1));
    check_op("post_op0", 0, 590, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
